// File: rtl/nmr_pkg.sv
// Shared helpers for the N-modular-redundant voter: sizing and replica slicing.
package nmr_pkg;

  // Ceiling log2 for constant sizing. clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  // Bits needed to hold a strike count from 0 up to and including the limit.
  function automatic int strike_width(input int strike_limit);
    return clog2(strike_limit + 1);
  endfunction

  // LSB of replica r inside the concatenated replica bus.
  function automatic int word_lsb(input int r, input int width);
    return r * width;
  endfunction

endpackage

// File: rtl/nmr_bit_vote.sv
// Majority of one bit column across N replicas, counting trusted replicas only.
module nmr_bit_vote
  import nmr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]           bits,
  input  logic [N-1:0]           trust,
  input  logic [clog2(N+1)-1:0]  active_count,
  output logic                   vote
);

  localparam int AW = clog2(N + 1);

  logic [AW-1:0] ones;

  // Popcount of trusted replicas that drive a 1 in this column.
  always_comb begin
    ones = '0;
    for (int r = 0; r < N; r++) begin
      ones = ones + AW'(bits[r] & trust[r]);
    end
  end

  // Strict majority: 2*ones > active; a tie (and active = 0) gives 0.
  assign vote = ({ones, 1'b0} > {1'b0, active_count});

endmodule

// File: rtl/nmr_voter.sv
// N-modular-redundant result voter with strike counting and sticky replica exclusion.
module nmr_voter
  import nmr_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int N            = 8,
  parameter int MIN_ACTIVE   = 3,
  parameter int STRIKE_LIMIT = 1,
  parameter int CONSECUTIVE  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*WIDTH-1:0]     in_data,
  input  logic                   clear_faults,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_error,
  output logic [N-1:0]           out_dissent,
  output logic [N-1:0]           fault_mask,
  output logic [clog2(N+1)-1:0]  active_count
);

  localparam int AW = clog2(N + 1);
  localparam int SW = strike_width(STRIKE_LIMIT);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_error_q, out_error_d;
  logic [N-1:0]     out_dissent_q, out_dissent_d;
  logic [N-1:0]     fault_mask_q, fault_mask_d;
  logic [AW-1:0]    active_count_q, active_count_d;
  logic [SW-1:0]    strike_q [N];
  logic [SW-1:0]    strike_d [N];

  logic [N-1:0]     trust;
  logic             accept;
  logic [WIDTH-1:0] vote_word;
  logic             vote_error;
  logic [N-1:0]     vote_dissent;

  assign trust      = ~fault_mask_q;
  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign vote_error = int'(active_count_q) < MIN_ACTIVE;

  // One majority voter per bit position, fed by that bit of every replica.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [N-1:0] column;
    for (genvar gr = 0; gr < N; gr++) begin : g_col
      assign column[gr] = in_data[word_lsb(gr, WIDTH) + gi];
    end
    nmr_bit_vote #(.N(N)) u_vote (
      .bits         (column),
      .trust        (trust),
      .active_count (active_count_q),
      .vote         (vote_word[gi])
    );
  end

  // A trusted replica dissents if any bit differs from the voted word.
  for (genvar gi = 0; gi < N; gi++) begin : g_dissent
    assign vote_dissent[gi] = trust[gi] &&
                              (in_data[word_lsb(gi, WIDTH) +: WIDTH] != vote_word);
  end

  // Next state: output register handshake, strike counting and mask update.
  always_comb begin
    logic [AW-1:0] excluded;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_error_d   = out_error_q;
    out_dissent_d = out_dissent_q;
    fault_mask_d  = fault_mask_q;
    strike_d      = strike_q;
    excluded      = '0;

    if (accept) begin
      out_valid_d   = 1'b1;
      out_data_d    = vote_word;
      out_error_d   = vote_error;
      out_dissent_d = vote_dissent;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear overrides any strikes earned by a transaction in the same cycle.
    if (clear_faults) begin
      fault_mask_d = '0;
      for (int r = 0; r < N; r++) strike_d[r] = '0;
    end else if (accept && !vote_error) begin
      for (int r = 0; r < N; r++) begin
        if (trust[r]) begin
          if (vote_dissent[r]) begin
            if (strike_q[r] < SW'(STRIKE_LIMIT)) strike_d[r] = strike_q[r] + 1'b1;
            if (strike_d[r] == SW'(STRIKE_LIMIT)) fault_mask_d[r] = 1'b1;
          end else if (CONSECUTIVE != 0) begin
            strike_d[r] = '0;
          end
        end
      end
    end

    for (int r = 0; r < N; r++) excluded = excluded + AW'(fault_mask_d[r]);
    active_count_d = AW'(N) - excluded;
  end

  // State registers, cleared asynchronously; a held output is dropped on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_error_q    <= 1'b0;
      out_dissent_q  <= '0;
      fault_mask_q   <= '0;
      active_count_q <= AW'(N);
      for (int r = 0; r < N; r++) strike_q[r] <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_error_q    <= out_error_d;
      out_dissent_q  <= out_dissent_d;
      fault_mask_q   <= fault_mask_d;
      active_count_q <= active_count_d;
      for (int r = 0; r < N; r++) strike_q[r] <= strike_d[r];
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_error    = out_error_q;
  assign out_dissent  = out_dissent_q;
  assign fault_mask   = fault_mask_q;
  assign active_count = active_count_q;

endmodule

// File: tb/tb_nmr_voter.sv
// Directed bench for nmr_voter: main instance (limit 1) plus two limit-2 instances
// that differ only in CONSECUTIVE.
module tb_nmr_voter;

  localparam int W = 32;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Main instance signals
  logic           a_valid, a_ready, a_clear, a_out_valid, a_out_ready, a_error;
  logic [N*W-1:0] a_data;
  logic [W-1:0]   a_out_data;
  logic [N-1:0]   a_dissent, a_mask;
  logic [3:0]     a_active;

  // Shared stimulus for the two strike-limit-2 instances
  logic           b_valid, b_clear, b_out_ready;
  logic [N*W-1:0] b_data;
  logic           c1_ready, c1_ov, c1_err, c0_ready, c0_ov, c0_err;
  logic [W-1:0]   c1_od, c0_od;
  logic [N-1:0]   c1_dis, c1_mask, c0_dis, c0_mask;
  logic [3:0]     c1_act, c0_act;

  nmr_voter #(.WIDTH(W), .N(N), .MIN_ACTIVE(3), .STRIKE_LIMIT(1), .CONSECUTIVE(0)) dut (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .clear_faults(a_clear), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_error(a_error), .out_dissent(a_dissent),
    .fault_mask(a_mask), .active_count(a_active)
  );

  nmr_voter #(.WIDTH(W), .N(N), .MIN_ACTIVE(3), .STRIKE_LIMIT(2), .CONSECUTIVE(1)) dut_c1 (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(c1_ready), .in_data(b_data),
    .clear_faults(b_clear), .out_valid(c1_ov), .out_ready(b_out_ready),
    .out_data(c1_od), .out_error(c1_err), .out_dissent(c1_dis),
    .fault_mask(c1_mask), .active_count(c1_act)
  );

  nmr_voter #(.WIDTH(W), .N(N), .MIN_ACTIVE(3), .STRIKE_LIMIT(2), .CONSECUTIVE(0)) dut_c0 (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(c0_ready), .in_data(b_data),
    .clear_faults(b_clear), .out_valid(c0_ov), .out_ready(b_out_ready),
    .out_data(c0_od), .out_error(c0_err), .out_dissent(c0_dis),
    .fault_mask(c0_mask), .active_count(c0_act)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    a_valid = 0; a_clear = 0; a_out_ready = 1; a_data = '0;
    b_valid = 0; b_clear = 0; b_out_ready = 1; b_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_mask", a_mask, 0);
    check("rst_active", a_active, 8);
    check("rst_in_ready", a_ready, 1);
    reset = 1'b1;
    $display("reset released");

    // Strike limit 2: dissent, agree, dissent on replica 5
    b_valid = 1; b_data = '0; b_data[5*W +: W] = 32'hFF;
    step();
    $display("b txn1: c1_mask=%0h c0_mask=%0h dissent=%0h", c1_mask, c0_mask, c1_dis);
    check("t3_dissent1", c1_dis, 8'h20);
    check("t3_c0_mask1", c0_mask, 0);
    b_data = '0;
    step();
    $display("b txn2: c1_mask=%0h c0_mask=%0h", c1_mask, c0_mask);
    b_data[5*W +: W] = 32'hFF;
    step();
    $display("b txn3: c1_mask=%0h c0_mask=%0h", c1_mask, c0_mask);
    check("t3_c1_mask", c1_mask, 0);
    check("t3_c0_mask", c0_mask, 8'h20);
    check("t3_c0_active", c0_act, 7);
    b_valid = 0;

    // 1: all replicas agree
    a_valid = 1; a_data = {N{32'h0000_00A5}};
    step();
    $display("txn A5: data=%0h dissent=%0h mask=%0h", a_out_data, a_dissent, a_mask);
    check("t1_valid", a_out_valid, 1);
    check("t1_data", a_out_data, 32'hA5);
    check("t1_dissent", a_dissent, 0);
    check("t1_mask", a_mask, 0);

    // 2: replica 3 disagrees and is excluded
    a_data = {N{32'h1234_5678}}; a_data[3*W +: W] = 32'hFFFF_FFFF;
    step();
    $display("txn r3 bad: data=%0h dissent=%0h mask=%0h act=%0d", a_out_data, a_dissent, a_mask, a_active);
    check("t2_data", a_out_data, 32'h1234_5678);
    check("t2_dissent", a_dissent, 8'h08);
    check("t2_mask", a_mask, 8'h08);
    check("t2_active", a_active, 7);

    // Replica 3 ignored: trusted ones = 3 of 7 -> 0
    a_data = '0;
    for (int r = 0; r < 4; r++) a_data[r*W +: W] = 32'h1;
    step();
    $display("txn r3 ignored: data=%0h dissent=%0h mask=%0h act=%0d", a_out_data, a_dissent, a_mask, a_active);
    check("t2_ignore_data", a_out_data, 0);
    check("t2_ignore_dissent", a_dissent, 8'h07);
    check("t2_ignore_mask", a_mask, 8'h0F);

    // 4: exclude 4 and 5 as well, leaving 2 active
    a_data = '0; a_data[4*W +: W] = 32'hFF; a_data[5*W +: W] = 32'hFF;
    step();
    $display("txn r4r5 bad: mask=%0h act=%0d", a_mask, a_active);
    check("t4_mask", a_mask, 8'h3F);
    check("t4_active", a_active, 2);

    // Error vote with a simultaneous clear: vote uses pre-clear mask
    a_data = '0; a_data[6*W +: W] = 32'h3; a_data[7*W +: W] = 32'h1; a_clear = 1;
    step();
    a_clear = 0;
    $display("txn error+clear: err=%0d data=%0h dissent=%0h mask=%0h act=%0d", a_error, a_out_data, a_dissent, a_mask, a_active);
    check("t4_error", a_error, 1);
    check("t4_err_data", a_out_data, 32'h1);
    check("t4_err_dissent", a_dissent, 8'h40);
    check("t4_clr_mask", a_mask, 0);
    check("t4_clr_active", a_active, 8);

    // Tie among 8 trusted replicas resolves to 0
    a_data = '0;
    for (int r = 0; r < 4; r++) a_data[r*W +: W] = 32'h1;
    step();
    $display("txn tie: err=%0d data=%0h dissent=%0h mask=%0h", a_error, a_out_data, a_dissent, a_mask);
    check("t4_tie_error", a_error, 0);
    check("t4_tie_data", a_out_data, 0);
    check("t4_tie_dissent", a_dissent, 8'h0F);
    a_valid = 0; a_clear = 1;
    step();
    a_clear = 0;
    $display("clear only: mask=%0h act=%0d valid=%0d", a_mask, a_active, a_out_valid);
    check("clr_mask", a_mask, 0);
    check("clr_active", a_active, 8);
    check("clr_out_valid", a_out_valid, 0);

    // 5: backpressure
    a_valid = 1; a_out_ready = 0; a_data = {N{32'h11}};
    #1 check("t5_ready_pre", a_ready, 1);
    step();
    $display("bp accept: data=%0h ready=%0d", a_out_data, a_ready);
    check("t5_bp_data", a_out_data, 32'h11);
    check("t5_bp_ready", a_ready, 0);
    a_data = {N{32'h22}};
    for (int i = 0; i < 2; i++) begin
      step();
      $display("bp hold %0d: data=%0h ready=%0d", i, a_out_data, a_ready);
      check("t5_hold_data", a_out_data, 32'h11);
      check("t5_hold_ready", a_ready, 0);
    end
    a_out_ready = 1;
    #1 check("t5_ready_rel", a_ready, 1);
    for (int k = 2; k <= 4; k++) begin
      step();
      $display("stream: data=%0h valid=%0d", a_out_data, a_out_valid);
      check("t5_stream_data", a_out_data, {N{k[3:0]}} & 32'hFF);
      check("t5_stream_valid", a_out_valid, 1);
      a_data = {N{32'h11 * (k + 1)}};
    end
    a_valid = 0;
    step();
    $display("stream drained: valid=%0d", a_out_valid);
    check("t5_drained", a_out_valid, 0);

    // 6: asynchronous reset while holding a vote with mask 0x04
    a_valid = 1; a_data = {N{32'h55}}; a_data[2*W +: W] = 32'hAA;
    step();
    a_valid = 0; a_out_ready = 0;
    $display("pre-reset: mask=%0h valid=%0d", a_mask, a_out_valid);
    check("t6_pre_mask", a_mask, 8'h04);
    check("t6_pre_valid", a_out_valid, 1);
    #2 reset = 1'b0;
    #1;
    $display("async reset: valid=%0d data=%0h mask=%0h", a_out_valid, a_out_data, a_mask);
    check("t6_rst_valid", a_out_valid, 0);
    check("t6_rst_data", a_out_data, 0);
    check("t6_rst_active", a_active, 8);
    @(negedge clk);
    reset = 1'b1; a_out_ready = 1;
    step();
    $display("post reset: mask=%0h valid=%0d", a_mask, a_out_valid);
    check("t6_post_mask", a_mask, 0);
    check("t6_post_valid", a_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
